// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// and the select/control codes driven into the datapath.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // Immediate format is a pure function of the opcode, independent of state.
  function automatic imm_src_t immSrcFor(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALU request plus funct fields onto the ALU operation code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_t    aluOp,
  input  logic [2:0] funct3,
  input  logic       opb5,
  input  logic       funct7b5,
  output logic [2:0] aluControl
);

  always_comb begin
    aluControl = ALU_ADD;
    case (aluOp)
      ALUOP_ADD: aluControl = ALU_ADD;
      ALUOP_SUB: aluControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type distinguishes sub; addi with imm[10]=1 must stay add.
          3'b000:  aluControl = (opb5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  aluControl = ALU_SLT;
          3'b110:  aluControl = ALU_OR;
          3'b111:  aluControl = ALU_AND;
          default: aluControl = ALU_ADD;
        endcase
      end
      default: aluControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I core. Sequences one instruction at a
// time through fetch/decode/execute/memory/writeback, stalling on mem_ready.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE  = 4'd0,
  parameter bit         ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  state_t  state, stateNext;
  logic    wasIllegal;
  alu_op_t aluOp;
  logic    pcUpdate, branch, irWriteRaw, memWriteRaw, regWriteRaw, illegalRaw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= state_t'(RESET_STATE);
      wasIllegal <= 1'b0;
    end else begin
      state      <= stateNext;
      wasIllegal <= (state == S_ILLEGAL);
    end
  end

  always_comb begin
    stateNext   = state;
    aluOp       = ALUOP_ADD;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    pcUpdate    = 1'b0;
    branch      = 1'b0;
    irWriteRaw  = 1'b0;
    memWriteRaw = 1'b0;
    regWriteRaw = 1'b0;
    illegalRaw  = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        irWriteRaw = mem_ready;
        pcUpdate   = mem_ready;
        if (mem_ready) stateNext = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: stateNext = S_MEMADR;
          OP_R:         stateNext = S_EXECR;
          OP_I:         stateNext = S_EXECI;
          OP_BEQ:       stateNext = S_BEQ;
          OP_JAL:       stateNext = S_JAL;
          default:      stateNext = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        stateNext = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) stateNext = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = RES_DATA;
        regWriteRaw = 1'b1;
        stateNext   = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        memWriteRaw = 1'b1;
        if (mem_ready) stateNext = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        aluOp     = ALUOP_FUNCT;
        stateNext = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        aluOp     = ALUOP_FUNCT;
        stateNext = S_ALUWB;
      end
      S_ALUWB: begin
        regWriteRaw = 1'b1;
        stateNext   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        aluOp     = ALUOP_SUB;
        branch    = 1'b1;
        stateNext = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pcUpdate  = 1'b1;
        stateNext = S_ALUWB;
      end
      S_ILLEGAL: begin
        // In hang mode the state persists, so the pulse keys off the entry cycle.
        illegalRaw = ~wasIllegal;
        stateNext  = ILLEGAL_TRAP ? S_FETCH : S_ILLEGAL;
      end
      default: stateNext = S_FETCH;
    endcase
  end

  alu_decoder u_aluDecoder (
    .aluOp      (aluOp),
    .funct3     (funct3),
    .opb5       (op[5]),
    .funct7b5   (funct7b5),
    .aluControl (alu_control)
  );

  // Enables are gated by rst_n so nothing writes in the cycle reset asserts.
  assign pc_write  = rst_n & (pcUpdate | (branch & zero));
  assign ir_write  = rst_n & irWriteRaw;
  assign mem_write = rst_n & memWriteRaw;
  assign reg_write = rst_n & regWriteRaw;
  assign illegal_o = rst_n & illegalRaw;
  assign imm_src   = immSrcFor(op);
  assign state_o   = state;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control unit for the multicycle RV32I core, built from the single-cycle datapath blocks (Extend, ALU, register file). It holds a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles, one instruction at a time. It decodes the opcode, funct3 and funct7b5 into ImmSrc for Extend and ALUControl for the ALU. It stalls on a memory ready handshake.

Parameters:
RESET_STATE, 4'd0 (S_FETCH), state entered on reset
ILLEGAL_TRAP, 1, if 1: an unknown opcode pulses illegal_o and returns to S_FETCH; if 0: the controller hangs in S_ILLEGAL

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
op  in  7  instr[6:0]
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the access this cycle
pc_write  out  1  PC register enable
adr_src  out  1  0=PC, 1=ALUOut to the memory address
mem_write  out  1  data memory write strobe
ir_write  out  1  instruction and OldPC register enable
reg_write  out  1  register file write enable
result_src  out  2  00=ALUOut, 01=Data, 10=ALUResult
alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1
alu_src_b  out  2  00=rs2, 01=ImmExt, 10=const 4
imm_src  out  2  00=I, 01=S, 10=B, 11=J; to Extend
alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
illegal_o  out  1  one-cycle pulse on an unsupported opcode
state_o  out  4  current state, for debug

Behaviour:
- States: S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL.
- Reset:
  - state goes to S_FETCH asynchronously.
  - While rst_n=0, pc_write, ir_write, mem_write, reg_write and illegal_o are forced to 0.
  - All other outputs take their S_FETCH values.
- S_FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, ALUOp=add, result_src=10.
  - ir_write and pc_write equal mem_ready.
  - Stay in S_FETCH while mem_ready=0; go to S_DECODE when mem_ready=1.
- S_DECODE: alu_src_a=01, alu_src_b=01, ALUOp=add (branch target). Next state by op:
  - 0000011 or 0100011: S_MEMADR
  - 0110011: S_EXECR
  - 0010011: S_EXECI
  - 1100011: S_BEQ
  - 1101111: S_JAL
  - any other op: S_ILLEGAL
- S_MEMADR: alu_src_a=10, alu_src_b=01, add. Go to S_MEMREAD if op=lw, else S_MEMWRITE.
- S_MEMREAD: result_src=00, adr_src=1. Hold until mem_ready=1, then S_MEMWB.
- S_MEMWB: result_src=01, reg_write=1, then S_FETCH.
- S_MEMWRITE: result_src=00, adr_src=1, mem_write=1.
  - mem_write stays high while waiting.
  - Exit to S_FETCH on the cycle mem_ready=1.
- S_EXECR: alu_src_a=10, alu_src_b=00, ALUOp=funct, then S_ALUWB.
- S_EXECI: alu_src_a=10, alu_src_b=01, ALUOp=funct, then S_ALUWB.
- S_ALUWB: result_src=00, reg_write=1, then S_FETCH.
- S_BEQ: alu_src_a=10, alu_src_b=00, ALUOp=sub, result_src=00, Branch=1, then S_FETCH.
- S_JAL: alu_src_a=01, alu_src_b=10, ALUOp=add, result_src=00, PCUpdate=1, then S_ALUWB.
- S_ILLEGAL: illegal_o=1 for one cycle. Then S_FETCH if ILLEGAL_TRAP=1, else stay in S_ILLEGAL until reset.
- pc_write = PCUpdate | (Branch & zero).
- Enables not listed for a state are 0. Selects not listed are 00.
- imm_src is combinational from op in every state:
  - lw, I-type: 00
  - sw: 01
  - beq: 10
  - jal: 11
  - other: 00
- alu_control, from ALUOp:
  - ALUOp=add: 000
  - ALUOp=sub: 001
  - ALUOp=funct, funct3=000: 001 if op[5]&funct7b5 (sub), else 000
  - ALUOp=funct, funct3=010: 101
  - ALUOp=funct, funct3=110: 011
  - ALUOp=funct, funct3=111: 010
  - ALUOp=funct, other funct3: 000
- Cycle counts:
  - lw: 5 cycles
  - sw: 4 cycles
  - R/I-type: 4 cycles
  - beq: 3 cycles
  - jal: 4 cycles
  - Each mem_ready=0 cycle in S_FETCH, S_MEMREAD or S_MEMWRITE adds one cycle.
- Reset asserted mid-instruction aborts it. No write enable may be high in the cycle reset asserts.
- The next state and outputs use op as sampled from the IR. The controller does not latch op itself.

Decomposition:
- riscv_ctrl_pkg holds:
  - the state enum
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - ImmSrc, ALUOp and ALUControl encodings
  - result_src and alu_src encodings
- One sub-module, alu_decoder: combinational; inputs ALUOp, funct3, op[5], funct7b5; output alu_control.
- The FSM and the imm_src decode stay in the top module.

Test Plan:
- Reset mid-S_MEMWRITE (rst_n low for 2 cycles) -> state_o=S_FETCH immediately, mem_write=0 during reset, and the fetch restarts after release.
- addi x2,x0,5 (0x00500113), mem_ready=1 -> states FETCH, DECODE, EXECI, ALUWB; imm_src=00, alu_control=000; reg_write=1 only in the 4th cycle.
- sw (0x0021A023) with mem_ready low for 2 cycles in S_MEMWRITE -> imm_src=01, mem_write held for 3 cycles, 6 cycles total, then S_FETCH.
- beq (0xFE420AE3):
  - zero=1 -> pc_write=1 in S_BEQ, imm_src=10, alu_control=001.
  - zero=0 -> pc_write=0.
- jal (0x008000EF) -> imm_src=11, pc_write=1 in S_JAL, reg_write=1 in the following S_ALUWB.
- sub R-type (0x40B50533) -> alu_control=001.
- slt R-type (0x00B52533) -> alu_control=101.
- op=0x7F -> illegal_o pulses 1 cycle after S_DECODE, then S_FETCH; no write enable is asserted.
